// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares a single UART transmitter among NUM_REQ byte-stream requesters.
//   Requesters are granted round-robin; the winner's byte and parity settings
//   are registered onto the TX inputs, a one-cycle data_valid pulse launches
//   the frame, and the arbiter then follows tx_busy until the frame is done.
//   If tx_busy never rises within BUSY_TIMEOUT cycles the frame is abandoned
//   and timeout_err pulses for one cycle.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   req_valid       : per-requester request, held until its req_ready pulse
//   req_data        : packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_par_en/typ  : per-requester parity enable / type (0 even, 1 odd)
//   req_ready       : one-hot single-cycle accept pulse
//   tx_p_data       : byte to the UART TX
//   tx_data_valid   : single-cycle launch pulse to the UART TX
//   tx_par_en/typ   : parity settings to the UART TX
//   tx_busy         : UART TX busy flag
//   grant_id        : index of the requester owning the TX
//   active          : high from launch until the frame completes or times out
//   timeout_err     : single-cycle pulse when tx_busy never rose
module uart_tx_arbiter #(
  parameter int  NUM_REQ      = 4,
  parameter int  DATA_W       = 8,
  parameter int  BUSY_TIMEOUT = 8,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_par_en,
  input  logic [NUM_REQ-1:0]        req_par_typ,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_p_data,
  output logic                      tx_data_valid,
  output logic                      tx_par_en,
  output logic                      tx_par_typ,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  localparam int               CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] busy_cnt_nx;
  logic             grant;
  logic             timeout_hit;
  logic [ID_W:0]    pick;
  logic [ID_W-1:0]  win_id;

  // Saturating increment of the busy-wait counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Round-robin pick: first asserted request scanning from ptr upward with
  // wrap. Returns {found, index}. Iterating from the far end lets the
  // nearest candidate overwrite the others.
  function automatic logic [ID_W:0] rr_pick(input logic [ID_W-1:0]    ptr,
                                            input logic [NUM_REQ-1:0] vld);
    logic [ID_W:0]   r;
    logic [ID_W-1:0] pos;
    int              idx;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      pos = ID_W'(idx);
      if (vld[pos]) r = {1'b1, pos};
    end
    return r;
  endfunction

  // Successor index modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] g);
    if (int'(g) == NUM_REQ - 1) return '0;
    return g + 1'b1;
  endfunction

  assign pick   = rr_pick(rr_ptr, req_valid);
  assign win_id = pick[ID_W-1:0];

  // Next-state and control decode. tx_data_valid, req_ready and active are
  // decoded from the registered state so they are glitch-free and reset to 0.
  always_comb begin
    state_nx      = state;
    busy_cnt_nx   = busy_cnt;
    grant         = 1'b0;
    timeout_hit   = 1'b0;
    tx_data_valid = 1'b0;
    req_ready     = '0;
    active        = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && pick[ID_W]) begin
          grant    = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_data_valid       = 1'b1;
        req_ready[grant_id] = 1'b1;
        active              = 1'b1;
        busy_cnt_nx         = '0;
        state_nx            = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        active = 1'b1;
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else begin
          busy_cnt_nx = sat_inc(busy_cnt);
          if (busy_cnt_nx == CNT_MAX) begin
            timeout_hit = 1'b1;
            state_nx    = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        active = 1'b1;
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control registers: FSM state, round-robin pointer, busy-wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      busy_cnt    <= busy_cnt_nx;
      timeout_err <= timeout_hit;
      if (grant) rr_ptr <= next_id(win_id);
    end
  end

  // Grant capture: the winner's byte and parity settings are sampled only in
  // the arbitration cycle and then held until the next grant, so requesters
  // may change their inputs freely once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_p_data  <= '0;
      tx_par_en  <= 1'b0;
      tx_par_typ <= 1'b0;
      grant_id   <= '0;
    end else if (grant) begin
      tx_p_data  <= req_data[int'(win_id)*DATA_W +: DATA_W];
      tx_par_en  <= req_par_en[win_id];
      tx_par_typ <= req_par_typ[win_id];
      grant_id   <= win_id;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus a randomized run
// compared against a queue/arithmetic reference of the round-robin rules.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 8;
  localparam int ID_W         = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_par_en;
  logic [NUM_REQ-1:0]        req_par_typ;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_p_data;
  logic                      tx_data_valid;
  logic                      tx_par_en;
  logic                      tx_par_typ;
  logic                      tx_busy;
  logic [ID_W-1:0]           grant_id;
  logic                      active;
  logic                      timeout_err;

  int checks = 0;
  int errors = 0;
  int model_rr = 0;

  logic [DATA_W-1:0] lane_d [NUM_REQ];
  logic              lane_pe[NUM_REQ];
  logic              lane_pt[NUM_REQ];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_par_en   (req_par_en),
    .req_par_typ  (req_par_typ),
    .req_ready    (req_ready),
    .tx_p_data    (tx_p_data),
    .tx_data_valid(tx_data_valid),
    .tx_par_en    (tx_par_en),
    .tx_par_typ   (tx_par_typ),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .active       (active),
    .timeout_err  (timeout_err)
  );

  // Reference arbitration: first pending requester at or after rr, modulo N.
  function automatic int model_pick(input int rr, input logic [NUM_REQ-1:0] pend);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pend[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = lane_d[i];
      req_par_en[i]  = lane_pe[i];
      req_par_typ[i] = lane_pt[i];
    end
  endtask

  task automatic wait_launch(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (tx_data_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = '0; tx_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_rr = 0;
  endtask

  task automatic serve_busy(input int n);
    tx_busy = 1'b1;
    repeat (n) tick();
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_d[i] = 8'($urandom); lane_pe[i] = 1'b0; lane_pt[i] = 1'b0;
    end
    drive_lanes();
    rst = 1'b1; req_valid = 4'b1111; tx_busy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      outs = {req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
              grant_id, active, timeout_err};
      checks++;
      if (outs !== 19'h0) begin
        errors++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, outs);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({tx_data_valid, req_ready, grant_id, tx_p_data} !== {1'b1, 4'b0001, 2'd0, lane_d[0]}) begin
      errors++;
      $display("FAIL reset_first_grant: got v=%b rdy=%b g=%0d d=%h expected v=1 rdy=0001 g=0 d=%h",
               tx_data_valid, req_ready, grant_id, tx_p_data, lane_d[0]);
    end
    model_rr = 1;
    req_valid = '0;
    serve_busy(3);
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL reset_frame_end: active=%b expected 0", active); end
  endtask

  task automatic test_single();
    lane_d[2] = 8'h69; lane_pe[2] = 1'b0; lane_pt[2] = 1'b0;
    drive_lanes();
    req_valid = 4'b0100;
    tick();
    checks++;
    if ({tx_data_valid, req_ready, tx_p_data, grant_id, active, tx_par_en} !==
        {1'b1, 4'b0100, 8'h69, 2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_launch: got v=%b rdy=%b d=%h g=%0d act=%b pe=%b expected v=1 rdy=0100 d=69 g=2 act=1 pe=0",
               tx_data_valid, req_ready, tx_p_data, grant_id, active, tx_par_en);
    end
    model_rr = 3;
    req_valid = '0;
    tx_busy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({active, tx_data_valid} !== 2'b10) begin
        errors++; $display("FAIL single_busy cycle %0d: act=%b v=%b expected act=1 v=0", c, active, tx_data_valid);
      end
    end
    tx_busy = 1'b0;
    tick();
    checks++;
    if ({active, tx_p_data} !== {1'b0, 8'h69}) begin
      errors++; $display("FAIL single_done: act=%b d=%h expected act=0 d=69", active, tx_p_data);
    end
  endtask

  task automatic test_round_robin();
    bit          seen;
    int          e;
    logic [1:0]  eg;
    logic [3:0]  erdy;
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_d[i] = 8'hA0 + 8'(i); lane_pe[i] = 1'($urandom); lane_pt[i] = 1'($urandom);
    end
    drive_lanes();
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_launch(4, seen);
      e = model_pick(model_rr, 4'b1111);
      eg = 2'(e);
      erdy = 4'b0001 << eg;
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rr_launch %0d: no tx_data_valid within 4 cycles, expected launch", n);
      end
      checks++;
      if ({grant_id, req_ready, tx_p_data} !== {eg, erdy, lane_d[e]}) begin
        errors++;
        $display("FAIL rr_grant %0d: got g=%0d rdy=%b d=%h expected g=%0d rdy=%b d=%h",
                 n, grant_id, req_ready, tx_p_data, eg, erdy, lane_d[e]);
      end
      model_rr = (e + 1) % NUM_REQ;
      serve_busy(3);
      checks++;
      if ({tx_data_valid, active} !== 2'b00) begin
        errors++; $display("FAIL rr_idle_gap %0d: v=%b act=%b expected 0 0", n, tx_data_valid, active);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_parity();
    bit seen;
    lane_d[1] = 8'h1E; lane_pe[1] = 1'b1; lane_pt[1] = 1'b1;
    lane_pe[0] = 1'b0; lane_pt[0] = 1'b0;
    drive_lanes();
    req_valid = 4'b0010;
    wait_launch(4, seen);
    checks++;
    if (!seen || {grant_id, tx_p_data, tx_par_en, tx_par_typ} !== {2'd1, 8'h1E, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL parity_launch: seen=%b g=%0d d=%h pe=%b pt=%b expected seen=1 g=1 d=1e pe=1 pt=1",
               seen, grant_id, tx_p_data, tx_par_en, tx_par_typ);
    end
    model_rr = 2;
    req_valid = '0;
    lane_d[1] = 8'hE1; lane_pe[1] = 1'b0; lane_pt[1] = 1'b0;
    drive_lanes();
    tx_busy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({tx_p_data, tx_par_en, tx_par_typ, grant_id} !== {8'h1E, 1'b1, 1'b1, 2'd1}) begin
        errors++;
        $display("FAIL parity_hold cycle %0d: d=%h pe=%b pt=%b g=%0d expected d=1e pe=1 pt=1 g=1",
                 c, tx_p_data, tx_par_en, tx_par_typ, grant_id);
      end
    end
    tx_busy = 1'b0;
    tick();
    checks++;
    if ({active, tx_p_data} !== {1'b0, 8'h1E}) begin
      errors++; $display("FAIL parity_done: act=%b d=%h expected act=0 d=1e", active, tx_p_data);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    lane_d[0] = 8'($urandom);
    drive_lanes();
    tx_busy = 1'b0;
    req_valid = 4'b0001;
    wait_launch(4, seen);
    checks++;
    if (!seen || {grant_id, tx_p_data} !== {2'd0, lane_d[0]}) begin
      errors++;
      $display("FAIL timeout_launch: seen=%b g=%0d d=%h expected seen=1 g=0 d=%h",
               seen, grant_id, tx_p_data, lane_d[0]);
    end
    model_rr = 1;
    req_valid = '0;
    for (int c = 0; c < BUSY_TIMEOUT; c++) begin
      tick();
      checks++;
      if ({timeout_err, active} !== 2'b01) begin
        errors++; $display("FAIL timeout_early cycle %0d: err=%b act=%b expected err=0 act=1", c, timeout_err, active);
      end
    end
    tick();
    checks++;
    if ({timeout_err, active} !== 2'b10) begin
      errors++; $display("FAIL timeout_pulse: err=%b act=%b expected err=1 act=0", timeout_err, active);
    end
    req_valid = 4'b1000;
    tick();
    checks++;
    if ({timeout_err, tx_data_valid, grant_id} !== {1'b0, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL timeout_recover: err=%b v=%b g=%0d expected err=0 v=1 g=3", timeout_err, tx_data_valid, grant_id);
    end
    model_rr = 0;
    req_valid = '0;
    serve_busy(2);
  endtask

  // Abort mid-frame with reset; first_id sets the owner, after which the
  // next grant must restart from requester 0.
  task automatic midframe_case(input logic [1:0] first_id);
    bit          seen;
    logic [18:0] outs;
    reset_dut();
    req_valid = 4'b0001 << first_id;
    if (first_id != 2'd0) begin
      req_valid = 4'b0001;
      wait_launch(3, seen);
      req_valid = '0;
      serve_busy(2);
      req_valid = 4'b0001 << first_id;
    end
    wait_launch(4, seen);
    checks++;
    if (!seen || grant_id !== first_id) begin
      errors++; $display("FAIL midrst_owner: seen=%b g=%0d expected seen=1 g=%0d", seen, grant_id, first_id);
    end
    req_valid = '0;
    tx_busy = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL midrst_active: act=%b expected 1", active); end
    rst = 1'b1;
    req_valid = 4'b1111;
    tick();
    outs = {req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ, grant_id, active, timeout_err};
    checks++;
    if (outs !== 19'h0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
    rst = 1'b0;
    tx_busy = 1'b0;
    tick();
    checks++;
    if ({tx_data_valid, grant_id, timeout_err} !== {1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_regrant: v=%b g=%0d err=%b expected v=1 g=0 err=0", tx_data_valid, grant_id, timeout_err);
    end
    model_rr = 1;
    req_valid = '0;
    serve_busy(2);
  endtask

  task automatic test_midframe_reset();
    midframe_case(2'd3);
    midframe_case(2'd1);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] add;
    bit                 seen;
    int                 e;
    int                 blen;
    int                 drop;
    logic [1:0]         eg;
    logic [3:0]         erdy;
    logic [DATA_W-1:0]  ed;
    logic               epe;
    logic               ept;
    pend = '0;
    tx_busy = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (pend == '0) begin
        add = 4'($urandom_range(1, 15));
        for (int i = 0; i < NUM_REQ; i++) begin
          if (add[i]) begin
            lane_d[i] = 8'($urandom); lane_pe[i] = 1'($urandom); lane_pt[i] = 1'($urandom);
          end
        end
        pend = add;
        drive_lanes();
        req_valid = pend;
      end
      e = model_pick(model_rr, pend);
      eg = 2'(e); erdy = 4'b0001 << eg;
      ed = lane_d[e]; epe = lane_pe[e]; ept = lane_pt[e];
      wait_launch(3, seen);
      checks++;
      if (!seen || {grant_id, req_ready, tx_p_data, tx_par_en, tx_par_typ} !== {eg, erdy, ed, epe, ept}) begin
        errors++;
        $display("FAIL rand_grant %0d: seen=%b g=%0d rdy=%b d=%h pe=%b pt=%b expected g=%0d rdy=%b d=%h pe=%b pt=%b",
                 n, seen, grant_id, req_ready, tx_p_data, tx_par_en, tx_par_typ, eg, erdy, ed, epe, ept);
      end
      model_rr = (e + 1) % NUM_REQ;
      pend[e] = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        lane_d[e] = 8'($urandom); lane_pe[e] = 1'($urandom); lane_pt[e] = 1'($urandom);
        pend[e] = 1'b1;
      end else begin
        lane_d[e] = 8'($urandom);
      end
      drive_lanes();
      req_valid = pend;
      if ($urandom_range(0, 4) == 0) begin
        repeat (BUSY_TIMEOUT) tick();
        tick();
        checks++;
        if ({timeout_err, active} !== 2'b10) begin
          errors++; $display("FAIL rand_timeout %0d: err=%b act=%b expected err=1 act=0", n, timeout_err, active);
        end
      end else begin
        blen = $urandom_range(2, 10);
        tx_busy = 1'b1;
        for (int j = 0; j < blen; j++) begin
          tick();
          if (j == blen / 2 && pend != '0 && $urandom_range(0, 1) == 1) begin
            drop = $urandom_range(0, NUM_REQ - 1);
            while (!pend[drop]) drop = (drop + 1) % NUM_REQ;
            pend[drop] = 1'b0;
            req_valid = pend;
          end
        end
        checks++;
        if ({tx_p_data, tx_par_en, tx_par_typ, grant_id, tx_data_valid} !== {ed, epe, ept, eg, 1'b0}) begin
          errors++;
          $display("FAIL rand_hold %0d: d=%h pe=%b pt=%b g=%0d v=%b expected d=%h pe=%b pt=%b g=%0d v=0",
                   n, tx_p_data, tx_par_en, tx_par_typ, grant_id, tx_data_valid, ed, epe, ept, eg);
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if ({active, tx_data_valid, timeout_err} !== 3'b000) begin
          errors++;
          $display("FAIL rand_done %0d: act=%b v=%b err=%b expected 0 0 0", n, active, tx_data_valid, timeout_err);
        end
      end
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_par_en = '0;
    req_par_typ = '0;
    tx_busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_parity();
    test_timeout();
    test_midframe_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
